// File: rtl/rxe_preamble_strip_pkg.sv
// Shared definitions for the RX preamble stripper: FSM states, widths and
// the preamble/SFD symbol patterns as functions of the symbol width.
package rxe_preamble_strip_pkg;

    localparam int unsigned PRE_LEN_W = 5;
    localparam int unsigned SYM_MAX_W = 8;

    typedef enum logic [2:0] {
        SYNC = 3'd0,
        IDLE = 3'd1,
        HUNT = 3'd2,
        BODY = 3'd3,
        PASS = 3'd4,
        DROP = 3'd5
    } state_t;

    // Preamble symbol: 01 repeated across the symbol (LSB pair first on the wire)
    function automatic logic [SYM_MAX_W-1:0] sym_pre(input int unsigned dw);
        logic [SYM_MAX_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < SYM_MAX_W / 2; i++) begin
            if (2 * i < dw) s[2*i +: 2] = 2'b01;
        end
        return s;
    endfunction

    // SFD symbol: preamble with the top bit pair replaced by 11
    function automatic logic [SYM_MAX_W-1:0] sym_sfd(input int unsigned dw);
        logic [SYM_MAX_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < SYM_MAX_W / 2; i++) begin
            if (2 * i + 2 == dw)  s[2*i +: 2] = 2'b11;
            else if (2 * i < dw)  s[2*i +: 2] = 2'b01;
        end
        return s;
    endfunction

endpackage

// File: rtl/rxe_preamble_strip_if.sv
// Symbol stream between RX pipeline stages: valid envelope, symbol, start-of-frame.
interface rxe_preamble_strip_if #(
    parameter int unsigned DW = 4
);
    logic          v;
    logic [DW-1:0] d;
    logic          sof;

    modport master (output v, output d, output sof);
    modport slave  (input v, input d);
endinterface

// File: rtl/rxe_preamble_strip.sv
// Receive-side preamble detector/stripper: hunts preamble, checks the SFD,
// forwards only the frame body with SOF, and counts dropped frames.
module rxe_preamble_strip
    import rxe_preamble_strip_pkg::*;
#(
    parameter int unsigned DW      = 4,
    parameter int unsigned MIN_PRE = 3,
    parameter int unsigned MAX_PRE = 31,
    parameter int unsigned CNTW    = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_ce,
    input  logic                  i_en,
    input  logic                  i_cancel,
    rxe_preamble_strip_if.slave   rx,
    rxe_preamble_strip_if.master  tx,
    output logic                  o_err,
    output logic [PRE_LEN_W-1:0]  o_pre_len,
    output logic [CNTW-1:0]       o_drop_cnt
);

    localparam logic [DW-1:0] PRE = DW'(sym_pre(DW));
    localparam logic [DW-1:0] SFD = DW'(sym_sfd(DW));
    localparam logic [PRE_LEN_W-1:0] MIN_CNT = PRE_LEN_W'(MIN_PRE);
    localparam logic [PRE_LEN_W-1:0] MAX_CNT = PRE_LEN_W'(MAX_PRE);

    state_t                 state_q, state_n;
    logic [PRE_LEN_W-1:0]   cnt_q, cnt_n;
    logic                   first_q, first_n;
    logic                   v_q, v_n;
    logic [DW-1:0]          d_q, d_n;
    logic                   sof_q, sof_n;
    logic                   err_q, err_n;
    logic [PRE_LEN_W-1:0]   pre_len_q, pre_len_n;
    logic [CNTW-1:0]        drop_q;
    logic                   drop_inc;

    // State and output registers; everything advances only on the symbol strobe
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= SYNC;
            cnt_q     <= '0;
            first_q   <= 1'b0;
            v_q       <= 1'b0;
            d_q       <= '0;
            sof_q     <= 1'b0;
            err_q     <= 1'b0;
            pre_len_q <= '0;
            drop_q    <= '0;
        end else if (i_ce) begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            first_q   <= first_n;
            v_q       <= v_n;
            d_q       <= d_n;
            sof_q     <= sof_n;
            err_q     <= err_n;
            pre_len_q <= pre_len_n;
            if (drop_inc && (drop_q != '1)) drop_q <= drop_q + CNTW'(1);
        end
    end

    // Next-state and next-output decode for one symbol
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        first_n   = first_q;
        v_n       = 1'b0;
        d_n       = d_q;
        sof_n     = 1'b0;
        err_n     = 1'b0;
        pre_len_n = pre_len_q;
        drop_inc  = 1'b0;

        unique case (state_q)
            SYNC: begin
                if (!rx.v) state_n = IDLE;
            end
            IDLE: begin
                if (rx.v) begin
                    if (!i_en) begin
                        state_n = PASS;
                        v_n     = 1'b1;
                        d_n     = rx.d;
                    end else if (rx.d == PRE) begin
                        state_n = HUNT;
                        cnt_n   = PRE_LEN_W'(1);
                    end else begin
                        state_n  = DROP;
                        err_n    = 1'b1;
                        drop_inc = 1'b1;
                    end
                end
            end
            HUNT: begin
                if (!rx.v) begin
                    // Frame ended inside the preamble: flag it and count it as lost
                    state_n  = IDLE;
                    err_n    = 1'b1;
                    drop_inc = 1'b1;
                end else if (rx.d == PRE) begin
                    if (cnt_q < MAX_CNT) cnt_n = cnt_q + PRE_LEN_W'(1);
                end else if ((rx.d == SFD) && (cnt_q >= MIN_CNT)) begin
                    state_n   = BODY;
                    pre_len_n = cnt_q;
                    first_n   = 1'b1;
                end else begin
                    state_n  = DROP;
                    err_n    = 1'b1;
                    drop_inc = 1'b1;
                end
            end
            BODY: begin
                if (rx.v) begin
                    v_n     = 1'b1;
                    d_n     = rx.d;
                    sof_n   = first_q;
                    first_n = 1'b0;
                end else begin
                    state_n = IDLE;
                end
            end
            PASS: begin
                if (rx.v) begin
                    v_n = 1'b1;
                    d_n = rx.d;
                end else begin
                    state_n = IDLE;
                end
            end
            DROP: begin
                if (!rx.v) state_n = IDLE;
            end
            default: begin
                state_n = SYNC;
            end
        endcase

        // Cancel overrides everything decided above for this symbol
        if (i_cancel) begin
            v_n       = 1'b0;
            d_n       = d_q;
            sof_n     = 1'b0;
            err_n     = 1'b0;
            pre_len_n = pre_len_q;
            first_n   = 1'b0;
            state_n   = rx.v ? DROP : IDLE;
            drop_inc  = rx.v && (state_q inside {IDLE, HUNT, BODY, PASS});
        end
    end

    assign tx.v       = v_q;
    assign tx.d       = d_q;
    assign tx.sof     = sof_q;
    assign o_err      = err_q;
    assign o_pre_len  = pre_len_q;
    assign o_drop_cnt = drop_q;

endmodule
